// File: rtl/awgn_pkg.sv
// awgn_pkg: shared widths, sample/variance types and estimator states
package awgn_pkg;
  localparam int SAMPLE_W = 16;
  localparam int VAR_W = 32;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [VAR_W-1:0] var_t;
  typedef enum logic [2:0] {IDLE, ACCUM, CALC1, CALC2, OUT} est_state_e;
endpackage

// File: rtl/awgn_stats_est_if.sv
// awgn_stats_est_if: sample-in / result-out handshake bundle for the statistics estimator
interface awgn_stats_est_if;
  import awgn_pkg::*;
  logic start;
  logic in_valid;
  logic in_ready;
  sample_t signal_in;
  logic out_valid;
  logic out_ready;
  sample_t mean_out;
  var_t var_out;
  logic busy;
  modport master (
    output start, in_valid, signal_in, out_ready,
    input in_ready, out_valid, mean_out, var_out, busy
  );
  modport slave (
    input start, in_valid, signal_in, out_ready,
    output in_ready, out_valid, mean_out, var_out, busy
  );
endinterface

// File: rtl/awgn_sq_accum.sv
// awgn_sq_accum: sum and sum-of-squares accumulator with a registered squarer stage
module awgn_sq_accum
  import awgn_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               i_clr,
  input  logic                               i_en,
  input  sample_t                            i_sample,
  output logic signed [SAMPLE_W+LOG2_N-1:0]  o_sum,
  output logic        [VAR_W+LOG2_N-1:0]     o_sumsq,
  output logic                               o_pend
);
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int SQ_W = VAR_W + LOG2_N;
  sample_t r_smp;
  logic r_pend;
  logic signed [SUM_W-1:0] r_sum;
  logic [SQ_W-1:0] r_sumsq;
  logic [VAR_W-1:0] w_sq;
  assign w_sq = VAR_W'(r_smp) * VAR_W'(r_smp);
  assign o_sum = r_sum;
  assign o_sumsq = r_sumsq;
  assign o_pend = r_pend;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_smp <= '0;
      r_pend <= 1'b0;
      r_sum <= '0;
      r_sumsq <= '0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
      r_sum <= '0;
      r_sumsq <= '0;
    end else begin
      r_pend <= i_en;
      if (i_en) r_smp <= i_sample;
      if (r_pend) begin
        r_sum <= r_sum + SUM_W'(r_smp);
        r_sumsq <= r_sumsq + SQ_W'(w_sq);
      end
    end
endmodule

// File: rtl/awgn_stats_est.sv
// awgn_stats_est: windowed mean/variance estimator over 2^LOG2_N samples
module awgn_stats_est
  import awgn_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input logic              clk,
  input logic              reset_n,
  awgn_stats_est_if.slave  bus
);
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int SQ_W = VAR_W + LOG2_N;
  est_state_e r_state;
  logic [LOG2_N:0] r_cnt;
  logic r_in_ready, r_out_valid, r_busy;
  logic signed [SUM_W-1:0] r_mean;
  logic [SQ_W-1:0] r_msq;
  sample_t r_mean_out;
  var_t r_var_out;
  logic w_acc, w_last, w_clr, w_pend;
  logic signed [SUM_W-1:0] w_sum;
  logic [SQ_W-1:0] w_sumsq;
  logic signed [SQ_W:0] w_sq_mean, w_var;
  assign w_acc = bus.in_valid && r_in_ready;
  assign w_last = w_acc && r_cnt == (LOG2_N+1)'((1 << LOG2_N) - 1);
  assign w_clr = r_state == IDLE && bus.start;
  assign w_sq_mean = (SQ_W+1)'(r_mean) * (SQ_W+1)'(r_mean);
  assign w_var = $signed({1'b0, r_msq}) - w_sq_mean;
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy = r_busy;
  assign bus.mean_out = r_mean_out;
  assign bus.var_out = r_var_out;
  awgn_sq_accum #(.LOG2_N(LOG2_N)) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_clr),
    .i_en     (w_acc),
    .i_sample (bus.signal_in),
    .o_sum    (w_sum),
    .o_sumsq  (w_sumsq),
    .o_pend   (w_pend)
  );
  // CALC1 waits for the squarer stage to retire the last sample before dividing
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_in_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy <= 1'b0;
      r_mean <= '0;
      r_msq <= '0;
      r_mean_out <= '0;
      r_var_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= ACCUM;
          r_cnt <= '0;
          r_in_ready <= 1'b1;
          r_busy <= 1'b1;
        end
        ACCUM: if (w_acc) begin
          r_cnt <= r_cnt + (LOG2_N+1)'(1);
          if (w_last) begin
            r_in_ready <= 1'b0;
            r_state <= CALC1;
          end
        end
        CALC1: if (!w_pend) begin
          r_mean <= w_sum >>> LOG2_N;
          r_msq <= w_sumsq >> LOG2_N;
          r_state <= CALC2;
        end
        CALC2: begin
          r_mean_out <= r_mean[SAMPLE_W-1:0];
          r_var_out <= w_var < 0 ? '0 : w_var[VAR_W-1:0];
          r_out_valid <= 1'b1;
          r_state <= OUT;
        end
        OUT: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
